seven_segment_scan_ctrl: RTL and testbench

//  Multi-digit, time-multiplexed seven-segment display controller. Accepts a DATA_W-bit binary

---
 rtl/seven_segment_scan_ctrl_pkg.sv | 18 +
 rtl/seven_segment_scan_ctrl_if.sv | 24 ++
 rtl/seven_segment_scan_ctrl_decoder.sv | 33 +++
 rtl/seven_segment_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_seven_segment_scan_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/seven_segment_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

  // 0-15 select a hex glyph; 16 and 17 are the blank and dash glyphs.
  typedef logic [4:0] digit_code_t;

  localparam digit_code_t CODE_BLANK = 5'd16;
  localparam digit_code_t CODE_DASH  = 5'd17;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Double-dabble correction applied to one BCD nibble before the shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seven_segment_scan_ctrl_if.sv
// Display request/status bundle between the datapath and the scan controller.
interface seven_segment_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DATA_W     = 14
);
  logic                  load;
  logic [DATA_W-1:0]     data_in;
  logic                  hex_mode;
  logic                  blank_lz;
  logic                  busy;
  logic                  overflow;
  logic [6:0]            segments;
  logic [NUM_DIGITS-1:0] digit_en;

  modport master (
    output load, data_in, hex_mode, blank_lz,
    input  busy, overflow, segments, digit_en
  );

  modport slave (
    input  load, data_in, hex_mode, blank_lz,
    output busy, overflow, segments, digit_en
  );
endinterface

// File: rtl/seven_segment_scan_ctrl_decoder.sv
// Combinational digit code to active-low gfedcba segment pattern.
module seg7_code_decoder
  import seg7_pkg::*;
(
  input  digit_code_t code_i,
  output logic [6:0]  seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      5'd0:    seg_o = 7'b1000000;
      5'd1:    seg_o = 7'b1111001;
      5'd2:    seg_o = 7'b0100100;
      5'd3:    seg_o = 7'b0110000;
      5'd4:    seg_o = 7'b0011001;
      5'd5:    seg_o = 7'b0010010;
      5'd6:    seg_o = 7'b0000010;
      5'd7:    seg_o = 7'b1111000;
      5'd8:    seg_o = 7'b0000000;
      5'd9:    seg_o = 7'b0010000;
      5'd10:   seg_o = 7'b0001000;
      5'd11:   seg_o = 7'b0000011;
      5'd12:   seg_o = 7'b1000110;
      5'd13:   seg_o = 7'b0100001;
      5'd14:   seg_o = 7'b0000110;
      5'd15:   seg_o = 7'b0001110;
      5'd17:   seg_o = 7'b0111111;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Binary-to-decimal/hex seven-segment controller with time-multiplexed digit scan.
module seven_segment_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DATA_W      = 14,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic                      clk,
  input logic                      rst_n,
  seven_segment_scan_ctrl_if.slave disp_io
);

  localparam int unsigned BcdW  = 4 * NUM_DIGITS;
  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
  localparam int unsigned CntW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned StepW = $clog2(DATA_W + 1);
  localparam longint unsigned DecLimit = 64'(10) ** NUM_DIGITS;

  state_t               state_q;
  logic [DATA_W-1:0]    bin_q, bin_shift;
  logic [BcdW-1:0]      bcd_q, bcd_adj, bcd_shift;
  logic [StepW-1:0]     step_q;
  logic                 hex_q, blank_q, ovf_cap_q;
  logic                 busy_q, overflow_q;
  digit_code_t          codes_q      [NUM_DIGITS];
  digit_code_t          codes_d      [NUM_DIGITS];
  digit_code_t          commit_codes [NUM_DIGITS];

  logic [CntW-1:0]       scan_q, scan_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [6:0]            segments_q, seg_dec;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

  // One double-dabble step over the combined {bcd, bin} shift register.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = dabble_adj(bcd_q[4*i +: 4]);
    end
    {bcd_shift, bin_shift} = {bcd_adj, bin_q} << 1;
  end

  // Result codes, walking from the top digit down so leading zeros can be blanked.
  always_comb begin
    logic [BcdW-1:0] digits;
    logic [3:0]      nib;
    logic            seen;
    commit_codes = '{default: CODE_BLANK};
    digits       = hex_q ? BcdW'(bin_q) : bcd_q;
    seen         = 1'b0;
    nib          = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = digits[4*i +: 4];
      if (ovf_cap_q) begin
        commit_codes[i] = CODE_DASH;
      end else if (blank_q && !seen && (nib == 4'd0) && (i != 0)) begin
        commit_codes[i] = CODE_BLANK;
      end else begin
        commit_codes[i] = {1'b0, nib};
      end
      if (nib != 4'd0) seen = 1'b1;
    end
  end

  always_comb begin
    if (state_q == COMMIT) codes_d = commit_codes;
    else                   codes_d = codes_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      hex_q      <= 1'b0;
      blank_q    <= 1'b0;
      ovf_cap_q  <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      codes_q    <= '{default: CODE_BLANK};
    end else begin
      codes_q <= codes_d;
      unique case (state_q)
        IDLE: begin
          if (disp_io.load) begin
            bin_q     <= disp_io.data_in;
            bcd_q     <= '0;
            step_q    <= '0;
            hex_q     <= disp_io.hex_mode;
            blank_q   <= disp_io.blank_lz;
            ovf_cap_q <= !disp_io.hex_mode && (64'(disp_io.data_in) >= DecLimit);
            busy_q    <= 1'b1;
            state_q   <= disp_io.hex_mode ? COMMIT : SHIFT;
          end
        end
        SHIFT: begin
          bcd_q  <= bcd_shift;
          bin_q  <= bin_shift;
          step_q <= step_q + 1'b1;
          if (step_q == StepW'(DATA_W - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          overflow_q <= ovf_cap_q;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are built from next-state index and codes so segments and enables move together.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == CntW'(REFRESH_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    digit_en_d = NUM_DIGITS'(1) << idx_d;
  end

  seg7_code_decoder u_decoder (
    .code_i (codes_d[idx_d]),
    .seg_o  (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q     <= '0;
      idx_q      <= '0;
      segments_q <= SEG_OFF;
      digit_en_q <= NUM_DIGITS'(1);
    end else begin
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      segments_q <= seg_dec;
      digit_en_q <= digit_en_d;
    end
  end

  assign disp_io.busy     = busy_q;
  assign disp_io.overflow = overflow_q;
  assign disp_io.segments = segments_q;
  assign disp_io.digit_en = digit_en_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed and randomized checks of the seven-segment scan controller against a digit model.
module tb_seven_segment_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 14;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_segment_scan_ctrl_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();

  seven_segment_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DATA_W      (DW),
    .REFRESH_DIV (RD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .disp_io (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [6:0] exp_seg [ND];
  logic       exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected glyph per digit from plain arithmetic on the displayed value.
  function automatic void model(input int unsigned v, input bit hex, input bit blz);
    int unsigned d [ND];
    int msd = 0;
    for (int i = 0; i < ND; i++) begin
      d[i] = hex ? ((v >> (4 * i)) & 15) : ((v / (10 ** i)) % 10);
      if (d[i] != 0) msd = i;
    end
    exp_ovf = !hex && (v >= 10 ** ND);
    for (int i = 0; i < ND; i++) begin
      if (exp_ovf)              exp_seg[i] = 7'b0111111;
      else if (blz && i > msd)  exp_seg[i] = 7'b1111111;
      else                      exp_seg[i] = seg_tab[d[i]];
    end
  endfunction

  task automatic start_load(input int unsigned v, input bit hex, input bit blz);
    @(negedge clk);
    bus.load     = 1'b1;
    bus.data_in  = DW'(v);
    bus.hex_mode = hex;
    bus.blank_lz = blz;
    @(posedge clk);
    #1 bus.load = 1'b0;
    @(negedge clk);
  endtask

  // Called at the first negedge after the accepting edge; returns at the negedge busy drops.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // One full scan period: every phase must be one-hot and show the model's glyph.
  task automatic check_display(input string tag);
    logic [ND-1:0] en;
    int idx;
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    for (int k = 0; k < ND * RD; k++) begin
      en  = bus.digit_en;
      idx = 0;
      for (int j = 0; j < ND; j++) if (en[j]) idx = j;
      check({tag, "_onehot"}, $countones(en), 1);
      check({tag, "_seg"}, 32'(bus.segments), 32'(exp_seg[idx]));
      @(negedge clk);
    end
  endtask

  task automatic run_load(input string tag, input int unsigned v, input bit hex, input bit blz);
    int cnt;
    start_load(v, hex, blz);
    wait_idle(cnt);
    check({tag, "_busy"}, cnt, hex ? 1 : DW + 1);
    model(v, hex, blz);
    check_display(tag);
  endtask

  initial begin
    int cnt;
    int unsigned v;
    bit h, b;
    bus.load     = 1'b0;
    bus.data_in  = '0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_seg", 32'(bus.segments), 32'h7F);
    check("rst_en", 32'(bus.digit_en), 32'h1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    rst_n = 1'b1;

    run_load("dec1234", 1234, 1'b0, 1'b0);
    run_load("dec7_blz", 7, 1'b0, 1'b1);
    run_load("dec0_blz", 0, 1'b0, 1'b1);
    run_load("dec12000", 12000, 1'b0, 1'b0);
    run_load("hex2A5F", 14'h2A5F, 1'b1, 1'b0);
    run_load("hex5_blz", 5, 1'b1, 1'b1);
    run_load("dec16383", 16383, 1'b0, 1'b1);
    run_load("dec9999", 9999, 1'b0, 1'b1);

    // Load pulsed while busy must be dropped
    start_load(42, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bus.load    = 1'b1;
    bus.data_in = DW'(99);
    @(posedge clk);
    #1 bus.load = 1'b0;
    @(negedge clk);
    wait_idle(cnt);
    check("drop_busy_left", cnt, DW + 1 - 5);
    model(42, 1'b0, 1'b0);
    check_display("drop42");
    check("drop_noqueue", 32'(bus.busy), 0);

    for (int r = 0; r < 6; r++) begin
      v = $urandom_range(16383, 0);
      h = 1'($urandom_range(1, 0));
      b = 1'($urandom_range(1, 0));
      run_load("rand", v, h, b);
    end

    // Reset mid-conversion aborts and blanks everything
    start_load(9999, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_ovf", 32'(bus.overflow), 0);
    for (int k = 0; k < 4 * ND * RD / 2; k++) begin
      check("abort_en", 32'(bus.digit_en), 32'(1 << ((k / RD) % ND)));
      check("abort_seg", 32'(bus.segments), 32'h7F);
      @(negedge clk);
    end

    run_load("after_abort", 305, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
